// File: rtl/addsub_acc_pipe.sv
// Pipelined two's-complement add/subtract unit with valid/ready handshake,
// carry/overflow/zero flags and an internal accumulator. Operands are
// combined in stage 0 at the accepting edge; the result word plus its flags
// then ride through STAGES registers alongside a valid bit. All stages move
// together when the output slot is empty or being drained.
module addsub_acc_pipe #(
    parameter int WIDTH  = 36,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [1:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o1,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic [WIDTH-1:0] acc
);

    // One pipeline slot: {zero, ovf, carry, result}
    localparam int PW = WIDTH + 3;

    // WIDTH+1 bit add or subtract; the top bit is the carry-out (no-borrow on subtract).
    function automatic logic [WIDTH:0] addsub_f(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             sub
    );
        logic [WIDTH-1:0] y_eff;
        y_eff = sub ? ~y : y;
        return {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
    endfunction

    logic             w_advance;
    logic             w_accept;
    logic             w_sub;
    logic [WIDTH-1:0] w_acc_eff;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_zero;
    logic [PW-1:0]    w_slot;

    logic [STAGES-1:0] r_vld;
    logic [PW-1:0]     r_slot [STAGES];
    logic [WIDTH-1:0]  r_acc;

    // The whole pipe moves only when the output slot is free or being consumed.
    assign w_advance = !r_vld[STAGES-1] || out_ready;
    assign w_accept  = in_valid && w_advance;

    // Operand selection: plain A op B, or accumulator op A (cleared accumulator reads as 0).
    always_comb begin
        w_acc_eff = acc_clr ? {WIDTH{1'b0}} : r_acc;
        w_sub     = op[0];
        if (op[1]) begin
            w_x = w_acc_eff;
            w_y = i1;
        end else begin
            w_x = i1;
            w_y = i2;
        end
    end

    // Stage-0 arithmetic and flag generation.
    always_comb begin
        w_sum   = addsub_f(w_x, w_y, w_sub);
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        // Overflow: effective operands share a sign and the result's sign differs.
        w_ovf   = (w_x[WIDTH-1] == (w_y[WIDTH-1] ^ w_sub)) && (w_res[WIDTH-1] != w_x[WIDTH-1]);
        w_zero  = (w_res == {WIDTH{1'b0}});
        w_slot  = {w_zero, w_ovf, w_carry, w_res};
    end

    // Result pipeline: shift every slot together on advance, hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                r_slot[i] <= {PW{1'b0}};
            end
        end else if (w_advance) begin
            r_vld[0]  <= in_valid;
            r_slot[0] <= w_slot;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_slot[i] <= r_slot[i-1];
            end
        end
    end

    // Accumulator: an accepted accumulate op writes its own result at the
    // accepting edge so back-to-back accumulates chain; a clear alone zeroes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= {WIDTH{1'b0}};
        end else if (w_accept && op[1]) begin
            r_acc <= w_res;
        end else if (acc_clr) begin
            r_acc <= {WIDTH{1'b0}};
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_vld[STAGES-1];
    assign o1        = r_slot[STAGES-1][WIDTH-1:0];
    assign carry     = r_slot[STAGES-1][WIDTH];
    assign ovf       = r_slot[STAGES-1][WIDTH+1];
    assign zero      = r_slot[STAGES-1][WIDTH+2];
    assign acc       = r_acc;

endmodule

// File: doc/addsub_acc_pipe.md
Name: addsub_acc_pipe

Overview:
- Parametrised, pipelined two's-complement add/subtract unit with valid/ready handshaking, a result-flag bundle and an internal accumulator.
- Next generation of the 36-bit combinational add/sub datapath. Adds configurable width and latency, four operation modes, backpressure and carry/overflow/zero flags.
- Sits between an operand producer and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 36, operand/result width in bits (>=2)
- STAGES, 2, register stages from accepted input to valid output (1..4)

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/op valid
- in_ready  output  1  block accepts input this cycle
- i1  input  WIDTH  operand A
- i2  input  WIDTH  operand B (ignored in accumulate modes)
- op  input  2  00 A+B, 01 A-B, 10 ACC+A, 11 ACC-A
- acc_clr  input  1  clear accumulator
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- o1  output  WIDTH  result
- carry  output  1  carry-out (subtract: 1 = no borrow)
- ovf  output  1  signed overflow
- zero  output  1  o1 == 0
- acc  output  WIDTH  current accumulator value

Behaviour:
- Reset (reset_n low, async): all stage valid bits 0; out_valid=0; o1, carry, ovf, zero = 0; acc=0. in_ready=1 from the first clock after reset deasserts.
  - Reset mid-operation discards all in-flight results; nothing is emitted for them.
- Handshake:
  - Input accepted when in_valid && in_ready. Output transferred when out_valid && out_ready.
  - advance = !out_valid || out_ready. in_ready = advance. All stages shift together only when advance=1; otherwise every stage holds.
  - Bubbles propagate as invalid slots; no bubble collapsing.
- Latency: an input accepted at edge N appears on out_valid/o1 after STAGES advancing edges. Full throughput is one result per cycle when out_ready=1.
- out_valid/o1/flags are stable while out_valid && !out_ready.
- Arithmetic, computed in stage 0 on acceptance:
  - X = i1 for op 00/01; X = acc_eff for op 10/11.
  - Y = i2 for op 00/01; Y = i1 for op 10/11.
  - sub = op[0]. sum = X + (sub ? ~Y : Y) + sub, computed WIDTH+1 bits wide.
  - o1 = sum[WIDTH-1:0]; carry = sum[WIDTH].
  - ovf = (X[MSB] == (Y[MSB]^sub)) && (o1[MSB] != X[MSB]).
  - zero = (o1 == 0).
  - Results wrap modulo 2^WIDTH.
- Accumulator:
  - acc_eff = acc_clr ? 0 : acc.
  - On an accepted op 10/11, acc <= o1 of that op at the accepting edge, so back-to-back accumulates chain with no hazard.
  - acc_clr with no accepted accumulate op: acc <= 0 at that edge.
  - acc_clr together with an accepted accumulate op: the op uses 0 as old value, and acc takes that op's result.
  - Ops 00/01 never modify acc.
  - acc_clr acts regardless of advance. Accumulate ops only update acc when accepted.
- Flags and o1 travel with their valid bit through all STAGES registers.

Test Plan:
- WIDTH=36, STAGES=2, out_ready=1: op=00, i1=0xFFFFFFFFF, i2=0x000000001 -> 2 cycles later out_valid=1, o1=0x000000000, carry=1, zero=1, ovf=0.
- op=01, i1=5, i2=7 -> o1=0xFFFFFFFFE, carry=0, ovf=0, zero=0. op=00, i1=0x7FFFFFFFF, i2=1 -> o1=0x800000000, ovf=1, carry=0.
- acc_clr pulse, then accepted ops 10 with i1=3, 10 with i1=4, 11 with i1=10 on consecutive cycles -> o1 sequence 3, 7, 0xFFFFFFFFD; acc=0xFFFFFFFFD; the op-10 results carry no false ovf.
- Stream 6 op=00 inputs with out_ready low for 3 cycles mid-stream -> in_ready=0 while out_valid && !out_ready; no result lost or duplicated; o1 is held stable during the stall; order is preserved.
- acc=20: acc_clr together with an accepted op 10, i1=9 -> o1=9, acc=9. acc_clr with no op -> acc=0 next edge; a concurrent op 00 does not touch acc.
- Two ops in flight, assert reset_n=0 asynchronously mid-cycle -> out_valid, o1, acc drop to 0 immediately; no stale result appears after release. Repeat the first scenario with STAGES=1 and STAGES=4 -> latency 1 and 4.
